// File: rtl/mips_multi_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// phases, with a retired-instruction counter and a sticky illegal-instruction flag.
module mips_multi_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  output logic             PC_write,
  output logic             Mem_write,
  output logic             lorD_mux,
  output logic             IR_write,
  output logic             Reg_Dst_mux,
  output logic             Mem_reg_mux,
  output logic             Reg_write,
  output logic             ALU_srcA_mux,
  output logic             Pc_src_mux,
  output logic             Branch,
  output logic [1:0]       ALU_srcB_mux,
  output logic [3:0]       ALU_control,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal_o
);

  // Handshake: enable is a plain run qualifier. A state advances only on a
  // rising edge with enable=1; with enable=0 the state and counter hold and
  // the write-enable strobes are suppressed.

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ADDIEXEC = 4'd10,
    ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state, state_next;
  logic [3:0] exec_alu;
  logic [3:0] funct_alu;
  logic       funct_ok;
  logic       illegal_set;
  logic       retire;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, branch_raw;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next  = state;
    illegal_set = 1'b0;
    if (enable) begin
      case (state)
        IDLE:   state_next = FETCH;
        FETCH:  state_next = DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_next = MEMADR;
            OP_BEQ:       state_next = BRANCH;
            OP_ADDI:      state_next = ADDIEXEC;
            OP_RTYPE: begin
              if (funct_ok) begin
                state_next = EXECUTE;
              end else begin
                state_next  = FETCH;
                illegal_set = 1'b1;
              end
            end
            default: begin
              state_next  = FETCH;
              illegal_set = 1'b1;
            end
          endcase
        end
        MEMADR:   state_next = (Op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  state_next = MEMWB;
        EXECUTE:  state_next = ALUWB;
        ADDIEXEC: state_next = ADDIWB;
        MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB: state_next = FETCH;
        default:  state_next = IDLE;
      endcase
    end
  end

  assign retire = enable && (state == MEMWB || state == MEMWRITE || state == ALUWB ||
                             state == BRANCH || state == ADDIWB);

  // The R-type ALU code is captured at decode so EXECUTE stays a pure state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      exec_alu    <= ALU_ADD;
      instr_count <= '0;
      illegal_o   <= 1'b0;
    end else begin
      state <= state_next;
      if (enable && state == DECODE) exec_alu <= funct_alu;
      if (retire) instr_count <= instr_count + 1'b1;
      if (illegal_set) illegal_o <= 1'b1;
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    branch_raw    = 1'b0;
    lorD_mux      = 1'b0;
    Reg_Dst_mux   = 1'b0;
    Mem_reg_mux   = 1'b0;
    ALU_srcA_mux  = 1'b0;
    Pc_src_mux    = 1'b0;
    ALU_srcB_mux  = 2'b00;
    ALU_control   = ALU_ADD;
    case (state)
      IDLE:     ALU_control = 4'b0000;
      FETCH:    begin ir_write_raw = 1'b1; pc_write_raw = 1'b1; ALU_srcB_mux = 2'b01; end
      DECODE:   ALU_srcB_mux = 2'b11;
      MEMADR:   begin ALU_srcA_mux = 1'b1; ALU_srcB_mux = 2'b10; end
      MEMREAD:  lorD_mux = 1'b1;
      MEMWB:    begin Mem_reg_mux = 1'b1; reg_write_raw = 1'b1; end
      MEMWRITE: begin lorD_mux = 1'b1; mem_write_raw = 1'b1; end
      EXECUTE:  begin ALU_srcA_mux = 1'b1; ALU_control = exec_alu; end
      ALUWB:    begin Reg_Dst_mux = 1'b1; reg_write_raw = 1'b1; end
      BRANCH: begin
        ALU_srcA_mux = 1'b1;
        ALU_control  = ALU_SUB;
        Pc_src_mux   = 1'b1;
        branch_raw   = 1'b1;
      end
      ADDIEXEC: begin ALU_srcA_mux = 1'b1; ALU_srcB_mux = 2'b10; end
      ADDIWB:   reg_write_raw = 1'b1;
      default:  ALU_control = 4'b0000;
    endcase
  end

  assign PC_write  = pc_write_raw  & enable;
  assign Mem_write = mem_write_raw & enable;
  assign IR_write  = ir_write_raw  & enable;
  assign Reg_write = reg_write_raw & enable;
  assign Branch    = branch_raw    & enable;
  assign state_o   = state;

endmodule

// File: tb/tb_mips_multi_control.sv
// Directed bench for mips_multi_control: a phase-list model per instruction
// class produces per-cycle expectations, checked on every falling edge.
module tb_mips_multi_control;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                 S_MEMWB = 5, S_MEMWRITE = 6, S_EXECUTE = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_ADDIEXEC = 10, S_ADDIWB = 11;
  localparam int W = 42;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [5:0]  Op, Funct;
  logic        PC_write, Mem_write, lorD_mux, IR_write, Reg_Dst_mux, Mem_reg_mux;
  logic        Reg_write, ALU_srcA_mux, Pc_src_mux, Branch;
  logic [1:0]  ALU_srcB_mux;
  logic [3:0]  ALU_control, state_o;
  logic [15:0] instr_count;
  logic        illegal_o;

  logic        s_pcw, s_memw, s_iord, s_irw, s_rdst, s_mreg, s_rw, s_sa, s_pcs, s_br;
  logic [1:0]  s_sb;
  logic [3:0]  s_alu, s_state;
  logic [3:0]  s_count;
  logic        s_ill;

  always #5 clk = ~clk;

  mips_multi_control dut (
    .clk(clk), .reset(reset), .enable(enable), .Op(Op), .Funct(Funct),
    .PC_write(PC_write), .Mem_write(Mem_write), .lorD_mux(lorD_mux), .IR_write(IR_write),
    .Reg_Dst_mux(Reg_Dst_mux), .Mem_reg_mux(Mem_reg_mux), .Reg_write(Reg_write),
    .ALU_srcA_mux(ALU_srcA_mux), .Pc_src_mux(Pc_src_mux), .Branch(Branch),
    .ALU_srcB_mux(ALU_srcB_mux), .ALU_control(ALU_control), .state_o(state_o),
    .instr_count(instr_count), .illegal_o(illegal_o)
  );

  mips_multi_control #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .enable(enable), .Op(Op), .Funct(Funct),
    .PC_write(s_pcw), .Mem_write(s_memw), .lorD_mux(s_iord), .IR_write(s_irw),
    .Reg_Dst_mux(s_rdst), .Mem_reg_mux(s_mreg), .Reg_write(s_rw),
    .ALU_srcA_mux(s_sa), .Pc_src_mux(s_pcs), .Branch(s_br),
    .ALU_srcB_mux(s_sb), .ALU_control(s_alu), .state_o(s_state),
    .instr_count(s_count), .illegal_o(s_ill)
  );

  // Model state
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_cnt;
  logic         m_ill;
  logic [3:0]   m_alu;
  int           n_pass, n_total;

  // Captures pinned against literal values after each scenario
  logic [3:0]   cap_exec_alu;
  logic [5:0]   cap_branch;
  logic         saw_wrap;
  logic [3:0]   prev_small;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b1111;
    endcase
  endfunction

  // Control pattern for a phase, straight from the per-phase output table.
  function automatic logic [19:0] exp_vec(input int ph, input logic en, input logic [3:0] alu_ex);
    logic pcw, memw, iord, irw, rdst, mreg, rw, sa, pcs, br;
    logic [1:0] sb;
    logic [3:0] alu;
    {pcw, memw, iord, irw, rdst, mreg, rw, sa, pcs, br} = '0;
    sb  = 2'b00;
    alu = 4'b0010;
    case (ph)
      S_IDLE:     alu = 4'b0000;
      S_FETCH:    begin irw = 1; pcw = 1; sb = 2'b01; end
      S_DECODE:   sb = 2'b11;
      S_MEMADR:   begin sa = 1; sb = 2'b10; end
      S_MEMREAD:  iord = 1;
      S_MEMWB:    begin mreg = 1; rw = 1; end
      S_MEMWRITE: begin iord = 1; memw = 1; end
      S_EXECUTE:  begin sa = 1; alu = alu_ex; end
      S_ALUWB:    begin rdst = 1; rw = 1; end
      S_BRANCH:   begin sa = 1; alu = 4'b0110; pcs = 1; br = 1; end
      S_ADDIEXEC: begin sa = 1; sb = 2'b10; end
      S_ADDIWB:   rw = 1;
      default:    alu = 4'b0000;
    endcase
    if (!en) {pcw, memw, irw, rw, br} = '0;
    return {4'(ph), pcw, memw, iord, irw, rdst, mreg, rw, sa, pcs, br, sb, alu};
  endfunction

  // One clock of stimulus; the DUT is expected to sit in phase ph this cycle.
  task automatic run_phase(input int ph, input logic en);
    enable = en;
    exp_q.push_back({m_ill, m_cnt, m_ill, m_cnt[3:0], exp_vec(ph, en, m_alu)});
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int freeze_at);
    int   seq [0:4];
    int   n;
    logic legal;
    Op = op;
    Funct = fn;
    m_alu = funct_alu(fn);
    seq = '{S_FETCH, S_DECODE, 0, 0, 0};
    n = 2;
    case (op)
      6'b100011: begin seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB}; n = 5; end
      6'b101011: begin seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, 0}; n = 4; end
      6'b000100: begin seq = '{S_FETCH, S_DECODE, S_BRANCH, 0, 0}; n = 3; end
      6'b001000: begin seq = '{S_FETCH, S_DECODE, S_ADDIEXEC, S_ADDIWB, 0}; n = 4; end
      6'b000000: if (funct_alu(fn) != 4'b1111) begin
        seq = '{S_FETCH, S_DECODE, S_EXECUTE, S_ALUWB, 0}; n = 4;
      end
      default: n = 2;
    endcase
    legal = (n > 2);
    for (int i = 0; i < n; i++) begin
      if (seq[i] == freeze_at) begin
        run_phase(seq[i], 1'b0);
        run_phase(seq[i], 1'b0);
      end
      run_phase(seq[i], 1'b1);
      if (!legal && seq[i] == S_DECODE) m_ill = 1'b1;
      if (legal && i == n - 1) m_cnt++;
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (state_o == 4'd7) cap_exec_alu = ALU_control;
    if (state_o == 4'd9) cap_branch = {Branch, Pc_src_mux, ALU_control};
    if (prev_small == 4'd15 && s_count == 4'd0) saw_wrap = 1'b1;
    prev_small = s_count;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      act = {illegal_o, instr_count, s_ill, s_count, state_o, PC_write, Mem_write, lorD_mux,
             IR_write, Reg_Dst_mux, Mem_reg_mux, Reg_write, ALU_srcA_mux, Pc_src_mux, Branch,
             ALU_srcB_mux, ALU_control};
      check("cycle_outputs", 64'(act), 64'(exp));
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    m_cnt = '0; m_ill = 1'b0; m_alu = 4'b0010;
    cap_exec_alu = '0; cap_branch = '0; saw_wrap = 1'b0; prev_small = '0;
    reset = 1'b0; enable = 1'b0; Op = '0; Funct = '0;

    @(posedge clk); #1;
    check("reset_outputs", 64'({state_o, PC_write, IR_write, ALU_srcB_mux, ALU_control,
                                instr_count, illegal_o}), 64'd0);
    run_phase(S_IDLE, 1'b0);
    run_phase(S_IDLE, 1'b1);
    reset = 1'b1;
    run_phase(S_IDLE, 1'b0);
    run_phase(S_IDLE, 1'b1);

    do_instr(6'b100011, 6'b000000, S_FETCH);
    check("lw_retired_count", 64'(instr_count), 64'd1);
    check("lw_back_to_fetch", 64'(state_o), 64'd1);

    do_instr(6'b101011, 6'b000000, S_MEMWRITE);
    do_instr(6'b000000, 6'b100010, -1);
    check("sub_exec_alu", 64'(cap_exec_alu), 64'(4'b0110));
    do_instr(6'b000000, 6'b100000, S_ALUWB);
    do_instr(6'b000000, 6'b100100, -1);
    do_instr(6'b000000, 6'b100101, -1);
    do_instr(6'b000000, 6'b100111, -1);
    check("nor_exec_alu", 64'(cap_exec_alu), 64'(4'b1100));
    do_instr(6'b000000, 6'b101010, -1);
    do_instr(6'b000100, 6'b000000, S_BRANCH);
    check("beq_branch_outputs", 64'(cap_branch), 64'(6'b11_0110));
    do_instr(6'b001000, 6'b000000, S_ADDIWB);
    check("count_after_ten", 64'(instr_count), 64'd10);

    do_instr(6'b111111, 6'b000000, -1);
    check("illegal_op_flag", 64'({illegal_o, instr_count}), 64'({1'b1, 16'd10}));
    do_instr(6'b000000, 6'b111000, -1);
    do_instr(6'b001000, 6'b000000, -1);
    check("illegal_sticky", 64'({illegal_o, instr_count}), 64'({1'b1, 16'd11}));

    for (int k = 0; k < 16; k++) do_instr(6'b101011, 6'b000000, -1);
    check("sw_burst_count", 64'({instr_count, s_count}), 64'({16'd27, 4'd11}));
    check("small_counter_wrapped", 64'(saw_wrap), 64'd1);

    // Reset in the middle of a load
    Op = 6'b100011;
    run_phase(S_FETCH, 1'b1);
    run_phase(S_DECODE, 1'b1);
    run_phase(S_MEMADR, 1'b1);
    #1;
    check("in_memread_before_abort", 64'(state_o), 64'd4);
    reset = 1'b0;
    #1;
    check("async_reset_clears", 64'({state_o, PC_write, Mem_write, lorD_mux, IR_write,
                                     Reg_write, ALU_srcB_mux, ALU_control, instr_count,
                                     illegal_o, s_count, s_ill}), 64'd0);
    m_cnt = '0;
    m_ill = 1'b0;
    run_phase(S_IDLE, 1'b1);
    reset = 1'b1;
    run_phase(S_IDLE, 1'b1);
    do_instr(6'b001000, 6'b000000, -1);
    check("restart_after_reset", 64'({illegal_o, instr_count, state_o}), 64'({1'b0, 16'd1, 4'd1}));

    @(negedge clk); #1;
    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
